// File: rtl/aha_reset_pkg.sv
// Shared types and constants for the CM3 reset/debug-power controller.
package aha_reset_pkg;

  typedef enum logic [1:0] {
    ST_POR_HOLD  = 2'd0,
    ST_RUN       = 2'd1,
    ST_SRST_HOLD = 2'd2,
    ST_SRST_WAIT = 2'd3
  } sys_state_e;

  localparam int CAUSE_POR    = 0;
  localparam int CAUSE_SYSREQ = 1;
  localparam int CAUSE_WDOG   = 2;

  localparam logic [2:0] CAUSE_RESET_VAL = 3'b001;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/aha_reset_ctrl_if.sv
// Request/acknowledge and reset-output bundle between the SoC/debugger side
// (master) and the reset controller (slave).
interface aha_reset_ctrl_if;

  logic       SYSRESETREQ;
  logic       WDOG_RESET_REQ;
  logic       DBGPWRUPREQ;
  logic       DBGPWRUPACK;
  logic       DBGSYSPWRUPREQ;
  logic       DBGSYSPWRUPACK;
  logic       DBGRSTREQ;
  logic       DBGRSTACK;
  logic       CPU_SYSRESETn;
  logic       DBG_RESETn;
  logic [2:0] RESET_CAUSE;
  logic       CLR_CAUSE;

  modport master (
    output SYSRESETREQ, WDOG_RESET_REQ, DBGPWRUPREQ, DBGSYSPWRUPREQ, DBGRSTREQ, CLR_CAUSE,
    input  DBGPWRUPACK, DBGSYSPWRUPACK, DBGRSTACK, CPU_SYSRESETn, DBG_RESETn, RESET_CAUSE
  );

  modport slave (
    input  SYSRESETREQ, WDOG_RESET_REQ, DBGPWRUPREQ, DBGSYSPWRUPREQ, DBGRSTREQ, CLR_CAUSE,
    output DBGPWRUPACK, DBGSYSPWRUPACK, DBGRSTACK, CPU_SYSRESETn, DBG_RESETn, RESET_CAUSE
  );

endinterface

// File: rtl/aha_pwr_handshake.sv
// Four-phase power-up REQ/ACK: ACK rises after DELAY consecutive edges with
// REQ high and falls on the first edge that sees REQ low.
module aha_pwr_handshake #(
  parameter int DELAY = 4,
  parameter int CNT_W = $clog2(DELAY + 1)
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_req,
  output logic o_ack
);

  localparam logic [CNT_W-1:0] TC      = CNT_W'(DELAY - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] r_cnt;
  logic             r_ack;

  // Delay counter and registered acknowledge; a dropped REQ aborts the count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
      r_ack <= 1'b0;
    end else if (!i_req) begin
      r_cnt <= '0;
      r_ack <= 1'b0;
    end else if (!r_ack) begin
      if (r_cnt == TC) begin
        r_ack <= 1'b1;
        r_cnt <= '0;
      end else if (r_cnt != CNT_MAX) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_ack = r_ack;

endmodule

// File: rtl/aha_reset_ctrl.sv
// CM3 reset sequencer, debug power/reset handshakes and sticky reset cause.
// Build option: AHA_RESET_CTRL_REQ_SYNC_EN adds 2-flop request synchronisers.
module aha_reset_ctrl
  import aha_reset_pkg::*;
#(
  parameter int SYSRST_HOLD_CYCLES = 16,
  parameter int DBGRST_HOLD_CYCLES = 8,
  parameter int PWRUP_DELAY        = 4
) (
  input  logic              MASTER_CLK,
  input  logic              PORESETn,
  aha_reset_ctrl_if.slave   bus
);

  localparam int CNT_W = $clog2(max3(SYSRST_HOLD_CYCLES, DBGRST_HOLD_CYCLES, PWRUP_DELAY) + 1);
  localparam logic [CNT_W-1:0] SYS_TC  = CNT_W'(SYSRST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] DBG_TC  = CNT_W'(DBGRST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [4:0] w_req_raw;
  logic [4:0] w_req;
  assign w_req_raw = {bus.DBGRSTREQ, bus.DBGSYSPWRUPREQ, bus.DBGPWRUPREQ,
                      bus.WDOG_RESET_REQ, bus.SYSRESETREQ};

`ifdef AHA_RESET_CTRL_REQ_SYNC_EN
  logic [4:0] r_sync1;
  logic [4:0] r_sync2;

  // Two-stage synchroniser for asynchronous request inputs.
  always_ff @(posedge MASTER_CLK or negedge PORESETn) begin
    if (!PORESETn) begin
      r_sync1 <= 5'b00000;
      r_sync2 <= 5'b00000;
    end else begin
      r_sync1 <= w_req_raw;
      r_sync2 <= r_sync1;
    end
  end
  assign w_req = r_sync2;
`else
  assign w_req = w_req_raw;
`endif

  logic w_sysreq, w_wdog, w_dbgpwr_req, w_dbgsys_req, w_dbgrst_req, w_any_req;
  assign w_sysreq     = w_req[0];
  assign w_wdog       = w_req[1];
  assign w_dbgpwr_req = w_req[2];
  assign w_dbgsys_req = w_req[3];
  assign w_dbgrst_req = w_req[4];
  assign w_any_req    = w_sysreq | w_wdog;

  logic w_dbgpwr_ack, w_dbgsys_ack;

  aha_pwr_handshake #(.DELAY(PWRUP_DELAY), .CNT_W(CNT_W)) u_dbgpwr (
    .i_clk(MASTER_CLK), .i_rst_n(PORESETn), .i_req(w_dbgpwr_req), .o_ack(w_dbgpwr_ack)
  );

  aha_pwr_handshake #(.DELAY(PWRUP_DELAY), .CNT_W(CNT_W)) u_dbgsys (
    .i_clk(MASTER_CLK), .i_rst_n(PORESETn), .i_req(w_dbgsys_req), .o_ack(w_dbgsys_ack)
  );

  sys_state_e       r_state;
  logic [CNT_W-1:0] r_sys_cnt;
  logic [CNT_W-1:0] w_sys_cnt_inc;
  logic             r_cpu_rstn;
  logic             w_por_done;

  assign w_sys_cnt_inc = (r_sys_cnt == CNT_MAX) ? r_sys_cnt : r_sys_cnt + CNT_W'(1);
  assign w_por_done    = (r_state == ST_POR_HOLD) && (r_sys_cnt == SYS_TC);

  // System reset FSM; the hold count is never restarted by late requests.
  always_ff @(posedge MASTER_CLK or negedge PORESETn) begin
    if (!PORESETn) begin
      r_state    <= ST_POR_HOLD;
      r_sys_cnt  <= '0;
      r_cpu_rstn <= 1'b0;
    end else begin
      case (r_state)
        ST_POR_HOLD: begin
          if (r_sys_cnt == SYS_TC) begin
            r_state    <= ST_RUN;
            r_sys_cnt  <= '0;
            r_cpu_rstn <= 1'b1;
          end else begin
            r_sys_cnt  <= w_sys_cnt_inc;
          end
        end
        ST_RUN: begin
          if (w_any_req) begin
            r_state    <= ST_SRST_HOLD;
            r_sys_cnt  <= '0;
            r_cpu_rstn <= 1'b0;
          end else begin
            r_cpu_rstn <= 1'b1;
          end
        end
        ST_SRST_HOLD: begin
          if (r_sys_cnt == SYS_TC) begin
            r_sys_cnt <= '0;
            if (w_any_req) begin
              r_state    <= ST_SRST_WAIT;
            end else begin
              r_state    <= ST_RUN;
              r_cpu_rstn <= 1'b1;
            end
          end else begin
            r_sys_cnt <= w_sys_cnt_inc;
          end
        end
        ST_SRST_WAIT: begin
          if (!w_any_req) begin
            r_state    <= ST_RUN;
            r_cpu_rstn <= 1'b1;
          end
        end
        default: begin
          r_state    <= ST_POR_HOLD;
          r_sys_cnt  <= '0;
          r_cpu_rstn <= 1'b0;
        end
      endcase
    end
  end

  logic             r_dbg_rstn;
  logic             r_dbg_busy;
  logic             r_dbg_drop;
  logic             r_dbgrst_ack;
  logic [CNT_W-1:0] r_dbg_cnt;

  // Debug reset: pending until the debug domain is powered and POR is done.
  // A request that drops during the hold forfeits its acknowledge.
  always_ff @(posedge MASTER_CLK or negedge PORESETn) begin
    if (!PORESETn) begin
      r_dbg_rstn   <= 1'b0;
      r_dbg_busy   <= 1'b0;
      r_dbg_drop   <= 1'b0;
      r_dbgrst_ack <= 1'b0;
      r_dbg_cnt    <= '0;
    end else if (r_state == ST_POR_HOLD) begin
      r_dbg_rstn <= w_por_done;
    end else if (r_dbg_busy) begin
      if (!w_dbgrst_req) r_dbg_drop <= 1'b1;
      if (r_dbg_cnt == DBG_TC) begin
        r_dbg_busy   <= 1'b0;
        r_dbg_cnt    <= '0;
        r_dbg_rstn   <= 1'b1;
        r_dbg_drop   <= 1'b0;
        r_dbgrst_ack <= w_dbgrst_req & ~r_dbg_drop;
      end else if (r_dbg_cnt != CNT_MAX) begin
        r_dbg_cnt <= r_dbg_cnt + CNT_W'(1);
      end
    end else if (r_dbgrst_ack) begin
      if (!w_dbgrst_req) r_dbgrst_ack <= 1'b0;
    end else if (w_dbgrst_req && w_dbgpwr_ack) begin
      r_dbg_busy <= 1'b1;
      r_dbg_cnt  <= '0;
      r_dbg_rstn <= 1'b0;
      r_dbg_drop <= 1'b0;
    end
  end

  logic [2:0] r_cause;
  logic [2:0] w_cause_set;

  // Cause bits latch only once the system FSM has left POR_HOLD.
  always_comb begin
    w_cause_set               = 3'b000;
    w_cause_set[CAUSE_POR]    = 1'b0;
    w_cause_set[CAUSE_SYSREQ] = w_sysreq & (r_state != ST_POR_HOLD);
    w_cause_set[CAUSE_WDOG]   = w_wdog & (r_state != ST_POR_HOLD);
  end

  // Sticky cause register; a same-cycle set beats the clear per bit.
  always_ff @(posedge MASTER_CLK or negedge PORESETn) begin
    if (!PORESETn) begin
      r_cause <= CAUSE_RESET_VAL;
    end else begin
      r_cause <= (bus.CLR_CAUSE ? 3'b000 : r_cause) | w_cause_set;
    end
  end

  assign bus.DBGPWRUPACK    = w_dbgpwr_ack;
  assign bus.DBGSYSPWRUPACK = w_dbgsys_ack;
  assign bus.DBGRSTACK      = r_dbgrst_ack;
  assign bus.CPU_SYSRESETn  = r_cpu_rstn;
  assign bus.DBG_RESETn     = r_dbg_rstn;
  assign bus.RESET_CAUSE    = r_cause;

endmodule
